// File: rtl/dsp_cic_corr_mult_mc.sv
// -----------------------------------------------------------------------------
// dsp_cic_corr_mult_mc
// Multi-channel CIC droop/gain correction multiplier. Time-multiplexed
// AXI-stream samples are multiplied by a per-channel signed coefficient taken
// from a writable table. The product is rounded half-up and shifted right by
// COEF_FRAC. It is then either saturated or wrapped back to DATA_WIDTH.
//
// Pipeline: S1 capture data+coef, S2 register, S3 multiply, S4 round/limit.
// Latency is 4 clocks and throughput is one sample per clock. All stages hold
// while the output is valid and not accepted.
//
// Build option:
//   CIC_CORR_SAT_EN  defined   -> clamp the rounded result to the DATA_WIDTH range
//                    undefined -> two's-complement wrap, no clamp logic
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast      input sample stream (signed data)
//   s_axis_tready                  input ready (pipeline enable)
//   m_axis_tdata/tvalid/tlast      corrected output stream
//   m_axis_tuser                   channel index of the output sample
//   m_axis_tready                  downstream ready
//   coef_wr/coef_addr/coef_data    coefficient table write port
//   frame_err, frame_err_clr       sticky framing error flag and its clear
// -----------------------------------------------------------------------------
module dsp_cic_corr_mult_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 18,
    parameter int COEF_FRAC  = 16,
    parameter int NUM_CHANS  = 8,
    parameter int CH_W       = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [CH_W-1:0]       m_axis_tuser,
    input  logic                  m_axis_tready,
    input  logic                  coef_wr,
    input  logic [CH_W-1:0]       coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic                  frame_err,
    input  logic                  frame_err_clr
);

    localparam int PROD_W    = DATA_WIDTH + COEF_WIDTH;
    localparam int R_W       = PROD_W + 1 - COEF_FRAC;
    localparam int TBL_DEPTH = 1 << CH_W;

    localparam logic [COEF_WIDTH-1:0] COEF_UNITY = COEF_WIDTH'(1) << COEF_FRAC;
    localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(NUM_CHANS - 1);
    localparam logic [PROD_W:0]       RND_HALF   = (PROD_W + 1)'(1) << (COEF_FRAC - 1);

    logic en;
    logic accept;

    logic [COEF_WIDTH-1:0] coef_tbl_q [TBL_DEPTH];
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  frame_err_q, frame_err_d;

    logic                         s1_valid_q, s2_valid_q, s3_valid_q, m_valid_q;
    logic signed [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
    logic signed [COEF_WIDTH-1:0] s1_coef_q, s2_coef_q;
    logic [CH_W-1:0]              s1_ch_q, s2_ch_q, s3_ch_q, m_ch_q;
    logic                         s1_last_q, s2_last_q, s3_last_q, m_last_q;
    logic signed [PROD_W-1:0]     s3_prod_q;
    logic [DATA_WIDTH-1:0]        m_data_q;

    logic [PROD_W:0]              rnd_sum;
    logic [DATA_WIDTH-1:0]        out_d;
    logic                         unused_rnd_bits;

    // The whole pipeline moves together; an empty output slot lets it fill.
    assign en            = ~m_valid_q | m_axis_tready;
    assign s_axis_tready = en;
    assign accept        = s_axis_tvalid & en;

    // Coefficient table. Writes ignore the stall; the S1 capture below reads
    // the pre-write value when address and channel collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                coef_tbl_q[i] <= COEF_UNITY;
            end
        end else if (coef_wr) begin
            coef_tbl_q[coef_addr] <= coef_data;
        end
    end

    // Channel counter and sticky framing error (set wins over clear).
    always_comb begin
        ch_d        = ch_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            if (s_axis_tlast || ch_q == CH_LAST) begin
                ch_d = '0;
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end
        if (accept && s_axis_tlast && ch_q != CH_LAST) begin
            frame_err_d = 1'b1;
        end else if (frame_err_clr) begin
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Round half-up on a one-bit-wider sum so the +half never overflows.
    assign rnd_sum = {s3_prod_q[PROD_W-1], s3_prod_q} + RND_HALF;

`ifdef CIC_CORR_SAT_EN
    localparam logic signed [R_W-1:0] R_MAX = R_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [R_W-1:0] R_MIN = R_W'(-(1 << (DATA_WIDTH - 1)));
    logic signed [R_W-1:0] rnd_r;

    assign rnd_r           = rnd_sum[PROD_W:COEF_FRAC];
    assign unused_rnd_bits = ^rnd_sum[COEF_FRAC-1:0];

    always_comb begin
        out_d = rnd_r[DATA_WIDTH-1:0];
        if (rnd_r > R_MAX) begin
            out_d = R_MAX[DATA_WIDTH-1:0];
        end else if (rnd_r < R_MIN) begin
            out_d = R_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    assign out_d           = rnd_sum[COEF_FRAC+DATA_WIDTH-1:COEF_FRAC];
    assign unused_rnd_bits = ^{rnd_sum[PROD_W:COEF_FRAC+DATA_WIDTH], rnd_sum[COEF_FRAC-1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_coef_q  <= '0;
            s1_ch_q    <= '0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_coef_q  <= '0;
            s2_ch_q    <= '0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_prod_q  <= '0;
            s3_ch_q    <= '0;
            s3_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_ch_q     <= '0;
            m_last_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q <= s_axis_tvalid;
            s1_data_q  <= s_axis_tdata;
            s1_coef_q  <= coef_tbl_q[ch_q];
            s1_ch_q    <= ch_q;
            s1_last_q  <= s_axis_tlast;

            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_data_q;
            s2_coef_q  <= s1_coef_q;
            s2_ch_q    <= s1_ch_q;
            s2_last_q  <= s1_last_q;

            s3_valid_q <= s2_valid_q;
            s3_prod_q  <= PROD_W'(s2_data_q) * PROD_W'(s2_coef_q);
            s3_ch_q    <= s2_ch_q;
            s3_last_q  <= s2_last_q;

            m_valid_q  <= s3_valid_q;
            m_data_q   <= out_d;
            m_ch_q     <= s3_ch_q;
            m_last_q   <= s3_last_q;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_ch_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_dsp_cic_corr_mult_mc.sv
module tb_dsp_cic_corr_mult_mc;

    localparam int DW   = 16;
    localparam int CW   = 18;
    localparam int FRAC = 16;
    localparam int NCH  = 8;
    localparam int CHW  = 3;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic [CHW-1:0] m_axis_tuser;
    logic          m_axis_tready;
    logic          coef_wr;
    logic [CHW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          frame_err;
    logic          frame_err_clr;

    dsp_cic_corr_mult_mc #(
        .DATA_WIDTH(DW), .COEF_WIDTH(CW), .COEF_FRAC(FRAC), .NUM_CHANS(NCH), .CH_W(CHW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .frame_err(frame_err), .frame_err_clr(frame_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0]  d;
        logic           last;
        logic [CHW-1:0] user;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: coefficient table, channel position, error flag.
    logic [CW-1:0] m_coef [NCH];
    int            m_ch;
    logic          m_fe;
    int            first_acc_cyc;
    int            first_out_cyc;
    bit            rdy_rand;
    logic          rdy_fixed;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] d, input logic [CW-1:0] c);
        longint p;
        longint r;
        p = longint'($signed(d)) * longint'($signed(c));
        r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef CIC_CORR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return DW'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_coef[i] = 18'h10000;
        m_ch = 0;
        m_fe = 1'b0;
    endtask

    // Downstream ready: random or fixed, changed only on falling edges.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_axis_tready = rdy_rand ? 1'($urandom % 2) : rdy_fixed;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = DW'($urandom);
            coef_wr       = 1'b0;
            frame_err_clr = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic last, input logic wr,
                              input logic [CHW-1:0] wa, input logic [CW-1:0] wd, input logic clr);
        int   waits;
        exp_t e;
        waits = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        coef_wr       = wr;
        coef_addr     = wa;
        coef_data     = wd;
        frame_err_clr = clr;
        #4;
        while (!s_axis_tready) begin
            if (wr) m_coef[wa] = wd;
            if (clr) m_fe = 1'b0;
            wr  = 1'b0;
            clr = 1'b0;
            @(negedge clk);
            coef_wr       = 1'b0;
            frame_err_clr = 1'b0;
            #4;
            waits++;
            if (waits > 200) begin
                $display("FAIL accept_timeout: actual=stalled required=accepted");
                $fatal(1, "input never accepted");
            end
        end
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        // Coefficient is read before a same-cycle write lands.
        e.d    = ref_out(d, m_coef[m_ch]);
        e.last = last;
        e.user = CHW'(m_ch);
        exp_q.push_back(e);
        if (last && m_ch != NCH - 1) m_fe = 1'b1;
        else if (clr) m_fe = 1'b0;
        m_ch = last ? 0 : (m_ch + 1) % NCH;
        if (wr) m_coef[wa] = wd;
    endtask

    task automatic write_coef(input logic [CHW-1:0] a, input logic [CW-1:0] dat);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = dat;
        m_coef[a] = dat;
        idle(1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        frame_err_clr = 1'b1;
        m_fe = 1'b0;
        idle(1);
    endtask

    task automatic send_frame(input logic [DW-1:0] d);
        for (int i = 0; i < NCH; i++) drive_beat(d, i == NCH - 1, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        idle(1);
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
        #4;
        check("frame_err", frame_err, m_fe);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks that
    // a stalled output holds still.
    initial begin
        logic          held;
        logic [DW-1:0] held_d;
        logic          held_l;
        logic [CHW-1:0] held_u;
        exp_t          e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_valid", m_axis_tvalid, 1);
                    check("stall_data", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                          {held_d, held_l, held_u});
                end
                held = 1'b0;
                if (m_axis_tvalid) begin
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    if (m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL extra_output: actual=0x%0h required=none", m_axis_tdata);
                        end else begin
                            e = exp_q.pop_front();
                            check("tdata", m_axis_tdata, e.d);
                            check("tlast", m_axis_tlast, e.last);
                            check("tuser", m_axis_tuser, e.user);
                        end
                    end else begin
                        held   = 1'b1;
                        held_d = m_axis_tdata;
                        held_l = m_axis_tlast;
                        held_u = m_axis_tuser;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; frame_err_clr = 1'b0;
        rdy_rand = 1'b0; rdy_fixed = 1'b1;
        first_acc_cyc = -1; first_out_cyc = -1;
        model_reset();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        #4;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_frame_err", frame_err, 0);

        // Unity gain pass-through and latency.
        send_frame(16'h1234);
        drain();
        check("latency", first_out_cyc - first_acc_cyc, 4);

        // Half gain with rounding in both signs.
        write_coef(3'd3, 18'h08000);
        send_frame(16'h0003);
        send_frame(16'hFFFD);
        drain();

        // Near-2x gain at full scale: saturation or wrap.
        write_coef(3'd0, 18'h1FFFF);
        send_frame(16'h7FFF);
        send_frame(16'h8000);
        drain();

        // Random traffic, random backpressure, occasional coefficient writes.
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom % 4 == 0) idle(1);
            drive_beat(DW'($urandom), m_ch == NCH - 1, ($urandom % 20) == 0,
                       CHW'($urandom), CW'($urandom), 1'b0);
        end
        drain();

        // Framing errors and the sticky flag.
        while (m_ch != 0) drive_beat(DW'($urandom), m_ch == NCH - 1, 1'b0, '0, '0, 1'b0);
        drive_beat(16'h0011, 1'b0, 1'b0, '0, '0, 1'b0);
        drive_beat(16'h0022, 1'b0, 1'b0, '0, '0, 1'b0);
        drive_beat(16'h0033, 1'b1, 1'b0, '0, '0, 1'b0);
        drain();
        drive_beat(16'h0044, 1'b0, 1'b0, '0, '0, 1'b0);
        drain();
        pulse_clr();
        drain();
        drive_beat(16'h0055, 1'b1, 1'b0, '0, '0, 1'b1);
        drain();
        pulse_clr();
        drain();

        // Coefficient write colliding with its own channel's acceptance.
        drive_beat(16'h0100, 1'b0, 1'b0, '0, '0, 1'b0);
        drive_beat(16'h0100, 1'b0, 1'b1, 3'd1, 18'h04000, 1'b0);
        for (int i = 2; i < NCH; i++) drive_beat(16'h0100, i == NCH - 1, 1'b0, '0, '0, 1'b0);
        send_frame(16'h0100);
        drain();

        // Asynchronous reset with samples in flight.
        rdy_fixed = 1'b0;
        idle(2);
        for (int i = 0; i < 3; i++) drive_beat(16'h0200, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(4);
        #4;
        check("pre_reset_valid", m_axis_tvalid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", m_axis_tvalid, 0);
        check("async_rst_tuser", m_axis_tuser, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        rdy_fixed = 1'b1;
        send_frame(16'h0100);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
